// File: rtl/adder_vec_seq.sv
// -----------------------------------------------------------------------------
// adder_vec_seq
// Stores a small table of 4-bit adder test vectors and plays the first
// `count` of them out to a downstream adder stage under valid/ready
// handshaking. The table is written only while the sequencer is idle, so a
// playback always sees a stable table.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   wr_en      vector-memory write strobe (honoured only in IDLE with start=0)
//   wr_addr    vector-memory write address
//   wr_data    vector word, [8:0] = {a[3:0], b[3:0], cin}, [10:9] unused
//   start      begin playback (accepted only in IDLE)
//   count      number of vectors to play, saturated to DEPTH
//   out_valid  a/b/cin/idx carry a valid vector
//   out_ready  downstream accepts the presented vector
//   a, b, cin  adder operands and carry-in
//   idx        memory index of the presented vector
//   busy       high in RUN and DONE
//   done       one-cycle pulse after the last vector is accepted
// -----------------------------------------------------------------------------
module adder_vec_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [10:0]   wr_data,
    input  logic          start,
    input  logic [AW:0]   count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    a,
    output logic [3:0]    b,
    output logic          cin,
    output logic [AW-1:0] idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   L_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   L_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] L_IDX_ZERO = AW'(0);
    localparam logic [AW-1:0] L_IDX_ONE  = AW'(1);

    state_t        r_state;
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_last;      // index of the final vector of this playback
    logic [AW-1:0] r_idx;
    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic          r_cin;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_wr_ok;
    logic [AW:0]   w_cnt_sat;
    logic [AW:0]   w_cnt_m1;
    logic          w_xfer;
    logic [AW-1:0] w_next_idx;
    logic [8:0]    w_first_vec;
    logic [8:0]    w_next_vec;

    // Write qualification, count saturation and next-vector lookup.
    always_comb begin
        w_wr_ok     = 1'b0;
        w_cnt_sat   = count;
        w_xfer      = r_valid & out_ready;
        w_next_idx  = r_idx + L_IDX_ONE;
        w_first_vec = r_mem[L_IDX_ZERO];
        w_next_vec  = r_mem[w_next_idx];

        // Reset and a same-cycle start both block table writes.
        if ((r_state == ST_IDLE) && wr_en && !start && !rst) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end

        if (count > L_DEPTH) begin
            w_cnt_sat = L_DEPTH;
        end else begin
            w_cnt_sat = count;
        end

        // Only used when w_cnt_sat >= 1, so the truncation below is exact.
        w_cnt_m1 = w_cnt_sat - L_CNT_ONE;
    end

    // Vector table: not reset, so stored vectors survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data[8:0];
        end
    end

    // Playback FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= L_IDX_ZERO;
            r_last  <= L_IDX_ZERO;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_cin   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_cnt_sat == L_CNT_ZERO) begin
                            // Nothing to play: straight to the done pulse.
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_valid <= 1'b1;
                            r_idx   <= L_IDX_ZERO;
                            r_last  <= w_cnt_m1[AW-1:0];
                            {r_a, r_b, r_cin} <= w_first_vec;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (r_idx == r_last) begin
                            // Last vector taken; a/b/cin/idx keep its value.
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= w_next_idx;
                            {r_a, r_b, r_cin} <= w_next_vec;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign cin       = r_cin;
    assign idx       = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
